// File: rtl/blram_arbiter.sv
// Round-robin arbiter sharing one single-port block RAM between two req/gnt masters,
// with a per-owner run-length limit and read-valid strobes aligned to the RAM's registered output.
module blram_arbiter #(
    parameter int SIZE  = 14,
    parameter int BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            req1,
    input  logic            we0,
    input  logic            we1,
    input  logic [SIZE-1:0] addr0,
    input  logic [SIZE-1:0] addr1,
    input  logic [31:0]     wdata0,
    input  logic [31:0]     wdata1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            rvalid0,
    output logic            rvalid1,
    output logic [31:0]     rdata,
    output logic            ram_we,
    output logic [SIZE-1:0] ram_addr,
    output logic [31:0]     ram_wdata,
    input  logic [31:0]     ram_rdata
);

    localparam logic [3:0] BURST_L = 4'(BURST);

    logic       r_last;
    logic [3:0] r_run;
    logic       w_keep;
    logic       w_pick1;
    logic       w_any;
    logic       w_port;

    // The current owner keeps the RAM only while its run is live and below the limit.
    assign w_keep  = (r_run != 4'd0) && (r_run < BURST_L);
    assign w_pick1 = w_keep ? r_last : ~r_last;
    assign w_any   = gnt0 | gnt1;
    assign w_port  = gnt1;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && req1) begin
                gnt0 = ~w_pick1;
                gnt1 = w_pick1;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_comb begin
        ram_addr  = addr0;
        ram_wdata = wdata0;
        if (gnt1) begin
            ram_addr  = addr1;
            ram_wdata = wdata1;
        end
        ram_we = (gnt0 & we0) | (gnt1 & we1);
    end

    assign rdata = ram_rdata;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_last  <= 1'b1;
            r_run   <= 4'd0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            if (w_any) begin
                if ((w_port == r_last) && (r_run != 4'd0)) begin
                    if (r_run != BURST_L) begin
                        r_run <= r_run + 4'd1;
                    end
                end else begin
                    r_last <= w_port;
                    r_run  <= 4'd1;
                end
            end else begin
                r_run <= 4'd0;
            end
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
        end
    end

endmodule

// File: tb/tb_blram_arbiter.sv
// Randomized + directed bench for blram_arbiter: a grant-history model and a shadow
// memory predict every grant, mux output and read response cycle by cycle.
module tb_blram_arbiter;

    localparam int SIZE  = 14;
    localparam int BURST = 4;
    localparam int WORDS = 1 << SIZE;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0, req1, we0, we1;
    logic [SIZE-1:0] addr0, addr1;
    logic [31:0]     wdata0, wdata1;
    logic            gnt0, gnt1, rvalid0, rvalid1, ram_we;
    logic [31:0]     rdata, ram_wdata, ram_rdata;
    logic [SIZE-1:0] ram_addr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem       [WORDS];
    logic [31:0] model_mem [WORDS];
    int          hist[$];
    int          prev_rd_port;
    logic [31:0] prev_rd_data;

    always #5 clk = ~clk;

    blram_arbiter #(.SIZE(SIZE), .BURST(BURST)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Block RAM stand-in: one-cycle registered read.
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Owner = most recent non-idle grant (1 after reset); run = trailing streak of that
    // owner with no idle cycle in between, capped at BURST.
    function automatic int model_grant(input logic r0, input logic r1);
        int owner = 1;
        int streak = 0;
        if (!r0 && !r1) return -1;
        if (r0 != r1) return r0 ? 0 : 1;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != -1) begin
                owner = hist[i];
                break;
            end
        end
        for (int i = hist.size() - 1; i >= 0 && streak < BURST; i--) begin
            if (hist[i] != owner) break;
            streak++;
        end
        if (streak >= 1 && streak < BURST) return owner;
        return 1 - owner;
    endfunction

    always @(negedge clk) begin
        int          g;
        logic        exp_we;
        logic [SIZE-1:0] a;
        logic [31:0] d;
        if (rst) begin
            check("reset_outputs", 32'({gnt0, gnt1, rvalid0, rvalid1, ram_we}), 32'd0);
            hist.delete();
            prev_rd_port = -1;
        end else begin
            check("rvalid", 32'({rvalid0, rvalid1}), 32'({prev_rd_port == 0, prev_rd_port == 1}));
            if (prev_rd_port >= 0) check("rdata", rdata, prev_rd_data);
            g = model_grant(req0, req1);
            check("gnt", 32'({gnt0, gnt1}), 32'({g == 0, g == 1}));
            exp_we = (g == 0) ? we0 : (g == 1) ? we1 : 1'b0;
            check("ram_we", 32'(ram_we), 32'(exp_we));
            prev_rd_port = -1;
            if (g >= 0) begin
                a = (g == 1) ? addr1 : addr0;
                d = (g == 1) ? wdata1 : wdata0;
                check("ram_addr", 32'(ram_addr), 32'(a));
                if (exp_we) begin
                    check("ram_wdata", ram_wdata, d);
                    model_mem[a] = d;
                end else begin
                    prev_rd_port = g;
                    prev_rd_data = model_mem[a];
                end
            end
            hist.push_back(g);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic r, input logic w, input int a, input logic [31:0] d);
        req0 = r; we0 = w; addr0 = SIZE'(a); wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input int a, input logic [31:0] d);
        req1 = r; we1 = w; addr1 = SIZE'(a); wdata1 = d;
    endtask

    initial begin
        int   burst_exp [16];
        logic g0, g1;
        for (int i = 0; i < WORDS; i++) begin
            mem[i]       = 32'(i) * 32'h9E37_79B1;
            model_mem[i] = 32'(i) * 32'h9E37_79B1;
        end
        mem[50]       = 32'h0000_002A;
        model_mem[50] = 32'h0000_002A;
        prev_rd_port  = -1;

        rst = 1'b1;
        set0(1'b1, 1'b0, 1, 32'd0);
        set1(1'b1, 1'b0, 2, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("rst_hold", 32'({gnt0, gnt1, rvalid0, rvalid1, ram_we}), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("first_gnt0", 32'(gnt0), 32'd1);
        check("first_gnt1", 32'(gnt1), 32'd0);
        tick();
        req0 = 1'b0; req1 = 1'b0;

        // Single read from port 1
        tick();
        set1(1'b1, 1'b0, 50, 32'd0);
        @(negedge clk);
        check("single_gnt1", 32'(gnt1), 32'd1);
        tick();
        req1 = 1'b0;
        @(negedge clk);
        check("single_rvalid1", 32'(rvalid1), 32'd1);
        check("single_rdata", rdata, 32'h0000_002A);
        check("single_rvalid0", 32'(rvalid0), 32'd0);

        // Write then read on port 0
        tick();
        set0(1'b1, 1'b1, 600, 32'hDEAD_BEEF);
        @(negedge clk);
        check("wr_gnt0", 32'(gnt0), 32'd1);
        tick();
        set0(1'b1, 1'b0, 600, 32'd0);
        @(negedge clk);
        check("rd_gnt0", 32'(gnt0), 32'd1);
        tick();
        req0 = 1'b0;
        @(negedge clk);
        check("wr_rd_rvalid0", 32'(rvalid0), 32'd1);
        check("wr_rd_rdata", rdata, 32'hDEAD_BEEF);

        // Burst fairness: make port 1 the owner, idle once, then contend
        tick();
        set1(1'b1, 1'b0, 20, 32'd0);
        tick();
        req1 = 1'b0;
        tick();
        set0(1'b1, 1'b0, 10, 32'd0);
        set1(1'b1, 1'b0, 20, 32'd0);
        for (int i = 0; i < 16; i++) burst_exp[i] = (i / 4) % 2;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("burst_%0d", i), 32'(gnt1), 32'(burst_exp[i]));
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;

        // Late arrival against a saturated run
        tick();
        set0(1'b1, 1'b0, 30, 32'd0);
        repeat (10) tick();
        set1(1'b1, 1'b0, 40, 32'd0);
        @(negedge clk);
        check("late_gnt1", 32'(gnt1), 32'd1);
        tick();
        req1 = 1'b0;
        tick();
        req0 = 1'b0;

        // Reset in the cycle of a read grant
        tick();
        set0(1'b1, 1'b0, 70, 32'd0);
        @(negedge clk);
        check("midrst_gnt0", 32'(gnt0), 32'd1);
        #2 rst = 1'b1;
        req0 = 1'b0;
        @(negedge clk);
        check("midrst_rvalid0", 32'(rvalid0), 32'd0);
        tick();
        rst = 1'b0;
        set0(1'b1, 1'b0, 71, 32'd0);
        set1(1'b1, 1'b0, 72, 32'd0);
        @(negedge clk);
        check("post_rst_gnt0", 32'(gnt0), 32'd1);
        tick();
        req0 = 1'b0;
        tick();
        req1 = 1'b0;

        // Randomized traffic with occasional resets
        repeat (800) begin
            @(negedge clk);
            g0 = gnt0;
            g1 = gnt1;
            tick();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
            if (!req0 || g0) begin
                if ($urandom_range(0, 2) != 0)
                    set0(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom);
                else
                    req0 = 1'b0;
            end
            if (!req1 || g1) begin
                if ($urandom_range(0, 2) != 0)
                    set1(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom);
                else
                    req1 = 1'b0;
            end
        end
        tick();
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
